am_stim_source_mux: RTL and testbench

- Parametrised successor to the fixed two-way test-signal mux in front of the AM demodulator.
- Selects one of NCH ADC channel streams or an internally generated AM test signal, and delivers it to the demod input with matched pipeline latency.
- The AM test signal is carrier × (1 + m·mod), with a programmable modulation index, rounding and saturation.
- Adds muted source switchover, output decimation strobe, and a sticky saturation flag.

---
 rtl/am_stim_source_mux.sv | 190 +++++++++++++++++++
 tb/tb_am_stim_source_mux.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/am_stim_source_mux.sv
// Source selector in front of the AM demodulator: NCH ADC channels or an internal
// AM test tone, latency-matched, with muted switchover, output decimation and sticky clip flag.
module am_stim_source_mux #(
  parameter int DW    = 8,
  parameter int CW    = 16,
  parameter int MIW   = 8,
  parameter int NCH   = 2,
  parameter int SELW  = 2,
  parameter int SHIFT = 23,
  parameter int FLUSH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NCH*DW-1:0]     ch_data,
  input  logic [CW-1:0]         carrier,
  input  logic [CW-1:0]         mod_data,
  input  logic [MIW-1:0]        mod_index,
  input  logic [SELW-1:0]       sel,
  input  logic [7:0]            decim,
  input  logic                  sat_clr,
  output logic [DW-1:0]         dout,
  output logic                  dout_valid,
  output logic [SELW-1:0]       sel_active,
  output logic                  sat_flag
);

  localparam int PW = 2 * CW;
  localparam int EW = CW + MIW + 1;
  localparam int MW = $clog2(FLUSH + 1);

  localparam logic signed [EW-1:0] ENV_BIAS = EW'(2 ** (CW - 2));
  localparam logic signed [PW:0]   RND      = (PW + 1)'(2 ** (SHIFT - 1));
  localparam logic signed [PW:0]   SAT_HI   = (PW + 1)'(2 ** (DW - 1) - 1);
  localparam logic signed [PW:0]   SAT_LO   = ~SAT_HI;

  // Round half up: add half an LSB of the retained part, then floor-shift.
  function automatic logic signed [PW:0] round_half_up(input logic signed [PW-1:0] p);
    round_half_up = ((PW + 1)'(p) + RND) >>> SHIFT;
  endfunction

  function automatic logic clips(input logic signed [PW:0] r);
    clips = (r > SAT_HI) || (r < SAT_LO);
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [PW:0] r);
    if (r > SAT_HI)
      saturate = {1'b0, {(DW - 1){1'b1}}};
    else if (r < SAT_LO)
      saturate = {1'b1, {(DW - 1){1'b0}}};
    else
      saturate = r[DW-1:0];
  endfunction

  logic signed [DW-1:0] adc_sel;
  logic                 am_sel;

  always_comb begin
    adc_sel = '0;
    for (int k = 0; k < NCH; k++)
      if (sel_active == SELW'(k)) adc_sel = ch_data[k*DW +: DW];
  end

  assign am_sel = (sel_active == SELW'(NCH));

  // ---- stage 1: input registers ----
  logic signed [CW-1:0] carrier_p1, mod_p1;
  logic [MIW-1:0]       idx_p1;
  logic signed [DW-1:0] adc_p1;
  logic                 am_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carrier_p1 <= '0;
      mod_p1     <= '0;
      idx_p1     <= '0;
      adc_p1     <= '0;
      am_p1      <= 1'b0;
    end else begin
      carrier_p1 <= carrier;
      mod_p1     <= mod_data;
      idx_p1     <= mod_index;
      adc_p1     <= adc_sel;
      am_p1      <= am_sel;
    end
  end

  // ---- stage 2: envelope 1 + m*mod, scaled so unity = 2^(CW-2) ----
  logic signed [EW-1:0] mod_prod, env_wide;
  logic signed [CW-1:0] carrier_p2, env_p2;
  logic signed [DW-1:0] adc_p2;
  logic                 am_p2;

  always_comb begin
    mod_prod = EW'(mod_p1) * EW'($signed({1'b0, idx_p1}));
    env_wide = ENV_BIAS + (mod_prod >>> (MIW + 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carrier_p2 <= '0;
      env_p2     <= '0;
      adc_p2     <= '0;
      am_p2      <= 1'b0;
    end else begin
      carrier_p2 <= carrier_p1;
      env_p2     <= env_wide[CW-1:0];
      adc_p2     <= adc_p1;
      am_p2      <= am_p1;
    end
  end

  // ---- stage 3: full-precision carrier * envelope ----
  logic signed [PW-1:0] p_p3;
  logic signed [DW-1:0] adc_p3;
  logic                 am_p3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_p3   <= '0;
      adc_p3 <= '0;
      am_p3  <= 1'b0;
    end else begin
      p_p3   <= PW'(carrier_p2) * PW'(env_p2);
      adc_p3 <= adc_p2;
      am_p3  <= am_p2;
    end
  end

  // ---- stage 4: round, saturate, mute and decimate into dout ----
  logic signed [PW:0]   rnd_s4;
  logic                 clip_s4;
  logic signed [DW-1:0] res_s4;

  always_comb begin
    rnd_s4  = round_half_up(p_p3);
    clip_s4 = am_p3 && clips(rnd_s4);
    res_s4  = am_p3 ? saturate(rnd_s4) : adc_p3;
  end

  logic [MW-1:0] mute_cnt;
  logic [7:0]    dec_cnt, dec_period;
  logic          strobe;

  assign strobe = (dec_cnt == 8'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_active <= '0;
      mute_cnt   <= MW'(FLUSH);
    end else if (sel != sel_active) begin
      sel_active <= sel;
      mute_cnt   <= MW'(FLUSH);
    end else if (mute_cnt != '0) begin
      mute_cnt   <= mute_cnt - MW'(1);
    end
  end

  // The period is latched at each strobe so a decim change never truncates a running period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_cnt    <= 8'd0;
      dec_period <= 8'd0;
    end else if (strobe) begin
      dec_period <= decim;
      dec_cnt    <= (decim == 8'd0) ? 8'd0 : 8'd1;
    end else begin
      dec_cnt    <= (dec_cnt == dec_period) ? 8'd0 : dec_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= strobe;
      if (strobe) dout <= (mute_cnt != '0) ? '0 : res_s4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sat_flag <= 1'b0;
    else if (clip_s4)
      sat_flag <= 1'b1;
    else if (sat_clr)
      sat_flag <= 1'b0;
  end

endmodule

// File: tb/tb_am_stim_source_mux.sv
// Scoreboard bench for am_stim_source_mux: a behavioural model predicts every cycle's
// outputs; a negedge monitor pops and compares.
module tb_am_stim_source_mux;

  localparam int DW = 8, CW = 16, MIW = 8, NCH = 2, SELW = 2, SHIFT = 23, FLUSH = 8;
  localparam int LAT = 4;

  logic              clk, reset_n;
  logic [NCH*DW-1:0] ch_data;
  logic [CW-1:0]     carrier, mod_data;
  logic [MIW-1:0]    mod_index;
  logic [SELW-1:0]   sel;
  logic [7:0]        decim;
  logic              sat_clr;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic [SELW-1:0]   sel_active;
  logic              sat_flag;

  am_stim_source_mux #(.DW(DW), .CW(CW), .MIW(MIW), .NCH(NCH), .SELW(SELW),
                       .SHIFT(SHIFT), .FLUSH(FLUSH)) dut (
    .clk(clk), .reset_n(reset_n), .ch_data(ch_data), .carrier(carrier),
    .mod_data(mod_data), .mod_index(mod_index), .sel(sel), .decim(decim),
    .sat_clr(sat_clr), .dout(dout), .dout_valid(dout_valid),
    .sel_active(sel_active), .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint val; bit am; bit clip; } samp_t;
  typedef struct { bit vld; longint dout; int sa; bit sat; } stat_t;

  samp_t  src_hist[$];   // source samples taken at each edge, oldest first
  stat_t  stat_q[$];
  longint strobe_q[$];

  int     m_sel_active, m_mute, m_left;
  longint m_dout;
  bit     m_sat;
  int     total = 0, bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // What the selected source presents right now, in plain integer arithmetic.
  function automatic samp_t source_of(input int sa);
    samp_t  s;
    longint env, p, r;
    s.am = 0; s.clip = 0; s.val = 0;
    if (sa < NCH) begin
      s.val = longint'($signed(ch_data[sa*DW +: DW]));
    end else if (sa == NCH) begin
      env = (longint'(1) << (CW - 2)) +
            ((longint'($signed(mod_data)) * longint'(mod_index)) >>> (MIW + 1));
      p = longint'($signed(carrier)) * env;
      r = (p + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
      s.am = 1;
      if (r > (2 ** (DW - 1) - 1)) begin s.clip = 1; s.val = 2 ** (DW - 1) - 1; end
      else if (r < -(2 ** (DW - 1))) begin s.clip = 1; s.val = -(2 ** (DW - 1)); end
      else s.val = r;
    end
    return s;
  endfunction

  task automatic model_reset();
    samp_t z;
    z.val = 0; z.am = 0; z.clip = 0;
    src_hist.delete();
    for (int i = 0; i < LAT - 1; i++) src_hist.push_back(z);
    m_sel_active = 0; m_mute = FLUSH; m_left = 0; m_dout = 0; m_sat = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    samp_t old, cap;
    stat_t st;
    bit    strobe;
    old = src_hist.pop_front();
    cap = source_of(m_sel_active);
    strobe = (m_left == 0);
    if (strobe) begin
      m_dout = (m_mute != 0) ? 0 : old.val;
      m_left = int'(decim);
    end else begin
      m_left--;
    end
    if (old.am && old.clip) m_sat = 1;
    else if (sat_clr) m_sat = 0;
    if (int'(sel) != m_sel_active) begin
      m_sel_active = int'(sel);
      m_mute = FLUSH;
    end else if (m_mute > 0) begin
      m_mute--;
    end
    src_hist.push_back(cap);
    st.vld = strobe; st.dout = m_dout; st.sa = m_sel_active; st.sat = m_sat;
    stat_q.push_back(st);
    if (strobe) strobe_q.push_back(m_dout);
  endtask

  always @(negedge clk) begin
    stat_t st;
    if (stat_q.size() > 0) begin
      st = stat_q.pop_front();
      chk("valid", dout_valid, st.vld);
      chk("dout_cycle", $signed(dout), st.dout);
      chk("sel_active", sel_active, st.sa);
      chk("sat_flag", sat_flag, st.sat);
    end
    if (dout_valid === 1'b1) begin
      if (strobe_q.size() == 0) chk("unexpected_strobe", 1, 0);
      else chk("strobe_dout", $signed(dout), strobe_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic rand_channels();
    for (int k = 0; k < NCH; k++) ch_data[k*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    int nv;
    reset_n = 0; ch_data = '0; carrier = '0; mod_data = '0; mod_index = '0;
    sel = '0; decim = '0; sat_clr = 0;
    #3;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_sel_active", sel_active, 0);
    chk("rst_sat", sat_flag, 0);
    @(negedge clk); #1 reset_n = 1;
    model_reset();

    // channel 0 with random data
    for (int i = 0; i < 20; i++) begin rand_channels(); step(); end

    // channel 1 ramp
    sel = 1;
    for (int i = 0; i < 12; i++) begin rand_channels(); step(); end
    for (int v = -128; v < 128; v++) begin
      ch_data[DW +: DW] = DW'(v);
      step();
    end
    chk("adc_no_sat", sat_flag, 0);

    // AM path, index zero then deep negative carrier
    sel = 2; carrier = 16'd16384; mod_index = 0; mod_data = 16'h1234;
    run(14);
    chk("am_idx0", $signed(dout), 32);
    carrier = 16'h8000; mod_data = 16'd32767; mod_index = 8'd255;
    run(6);
    chk("am_neg_full", $signed(dout), -128);
    chk("am_neg_nosat", sat_flag, 0);

    // saturation, sat_clr coinciding with clips, then a clean clear
    carrier = 16'd32767;
    run(5);
    chk("sat_dout", $signed(dout), 127);
    chk("sat_set", sat_flag, 1);
    sat_clr = 1;
    run(3);
    chk("sat_clr_vs_clip", sat_flag, 1);
    carrier = 16'd0;
    run(6);
    chk("sat_cleared", sat_flag, 0);
    sat_clr = 0;

    // switchover with a second change during the mute
    sel = 0;
    for (int i = 0; i < 12; i++) begin rand_channels(); step(); end
    carrier = 16'd16384; mod_index = 0; ch_data[DW +: DW] = 8'd77;
    sel = 2;
    step();
    chk("switch_sel_active", sel_active, 2);
    run(2);
    sel = 1;
    step();
    chk("switch2_sel_active", sel_active, 1);
    run(FLUSH);
    chk("switch_muted_end", $signed(dout), 0);
    step();
    chk("switch_unmuted", $signed(dout), 77);

    // decimation by 4, then a mid-period change to 2
    decim = 3;
    for (int i = 0; i < 8; i++) begin rand_channels(); step(); end
    nv = 0;
    for (int i = 0; i < 16; i++) begin rand_channels(); step(); nv += int'(dout_valid); end
    chk("decim4_count", nv, 4);
    for (int i = 0; i < 8 && dout_valid !== 1'b1; i++) begin rand_channels(); step(); end
    rand_channels(); step();
    decim = 1;
    for (int i = 0; i < 12; i++) begin rand_channels(); step(); end

    // randomized soak
    for (int i = 0; i < 1500; i++) begin
      rand_channels();
      if ($urandom_range(1, 0) == 1) begin
        carrier  = $urandom_range(1, 0) ? 16'h7FFF - CW'($urandom_range(300, 0))
                                        : 16'h8000 + CW'($urandom_range(300, 0));
        mod_data = 16'h7FFF - CW'($urandom_range(2000, 0));
        mod_index = 8'd255 - MIW'($urandom_range(20, 0));
      end else begin
        carrier = CW'($urandom); mod_data = CW'($urandom); mod_index = MIW'($urandom);
      end
      if ($urandom_range(39, 0) == 0) sel = SELW'($urandom_range(3, 0));
      if ($urandom_range(29, 0) == 0) decim = 8'($urandom_range(5, 0));
      sat_clr = ($urandom_range(7, 0) == 0);
      step();
    end
    sat_clr = 0;

    // mid-stream asynchronous reset
    sel = 0; decim = 0; ch_data[0 +: DW] = 8'd55;
    run(20);
    chk("pre_reset_dout", $signed(dout), 55);
    @(negedge clk); #1 reset_n = 0;
    #1;
    chk("async_rst_dout", dout, 0);
    chk("async_rst_valid", dout_valid, 0);
    chk("async_rst_sel", sel_active, 0);
    chk("async_rst_sat", sat_flag, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset_n = 1;
    model_reset();
    step();
    chk("post_rst_first_valid", dout_valid, 1);
    chk("post_rst_first_dout", $signed(dout), 0);
    run(FLUSH - 1);
    chk("post_rst_mute_end", $signed(dout), 0);
    step();
    chk("post_rst_ch0", $signed(dout), 55);
    run(4);

    @(negedge clk); #1;
    chk("stat_q_drained", stat_q.size(), 0);
    chk("strobe_q_drained", strobe_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
